line_buf_3row: RTL and testbench
================================

LINE_BUF_3ROW -- requirements
Module: line_buf_3row

Interface
REQ-001 The block SHALL have parameter BIT_LEN, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 417, pixels per row (padded feature-map width).
REQ-003 The block SHALL have parameter IMG_H, default 417, rows per frame.
REQ-004 The block SHALL have port i_Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1, reset; asynchronous and active-high.
REQ-006 The block SHALL have port i_pix, input, BIT_LEN, raster-order pixel.
REQ-007 The block SHALL have port i_valid, input, 1, i_pix is valid this cycle.
REQ-008 The block SHALL have port i_sof, input, 1, start of frame, qualified by i_valid, marks pixel (row 0, col 0).
REQ-009 The block SHALL have port o_dato0, output, BIT_LEN, pixel of the current row r (LSB lane of the 3x3 conv stage).
REQ-010 The block SHALL have port o_dato1, output, BIT_LEN, same column, row r-1.
REQ-011 The block SHALL have port o_dato2, output, BIT_LEN, same column, row r-2 (MSB lane).
REQ-012 The block SHALL have port o_valid, output, 1, o_dato0..2 form a valid vertical 3-pixel column.
REQ-013 The block SHALL have port o_eol, output, 1, the current output column is col IMG_W-1.
REQ-014 The block SHALL have port o_eof, output, 1, the current output column is (row IMG_H-1, col IMG_W-1).

Function
REQ-015 The block SHALL hold two row memories, line0 (row r-1) and line1 (row r-2), each IMG_W x BIT_LEN, indexed by column counter col.
REQ-016 On an accepted pixel (i_valid=1), it SHALL register o_dato0<=i_pix, o_dato1<=line0[col] (old value), o_dato2<=line1[col] (old value), then write line1[col]<=old line0[col] and line0[col]<=i_pix in the same cycle.
REQ-017 Latency SHALL be exactly 1 clock from accepted i_pix to the corresponding o_dato0.
REQ-018 col SHALL increment per accepted pixel and wrap IMG_W-1 -> 0; on wrap, row SHALL increment, and row IMG_H-1 SHALL wrap to 0.
REQ-019 A row-fill counter SHALL saturate at 2: 0 after reset or sof, +1 per completed row.
REQ-020 o_valid SHALL be 1 for exactly one cycle per accepted pixel when row-fill = 2 at acceptance; otherwise 0.
REQ-021 With i_valid=0, counters, memories and o_dato0..2 SHALL hold; o_valid, o_eol and o_eof SHALL be 0.
REQ-022 i_valid=1 with i_sof=1 SHALL force that pixel to col 0, row 0, row-fill 0 regardless of current state (mid-row restart); line memory contents are not cleared.
REQ-023 o_eol SHALL be 1 together with o_valid only for col IMG_W-1; o_eof additionally requires row IMG_H-1.
REQ-024 A frame end (row IMG_H-1 wrap) without i_sof SHALL reset row-fill to 0, so the next frame never mixes rows across frames.
REQ-025 Counter widths SHALL be $clog2(IMG_W) and $clog2(IMG_H); no arithmetic on pixel data.

Reset
REQ-026 Asserting i_reset SHALL immediately set o_dato0..2=0, o_valid=0, o_eol=0, o_eof=0, col=0, row=0, row-fill=0.
REQ-027 Line memory contents SHALL NOT require reset; o_valid gating guarantees they are never output before being written.
REQ-028 Reset asserted mid-row SHALL discard the partial frame; the first pixel after deassertion is treated as (row 0, col 0).

Structure
REQ-029 BIT_LEN, IMG_W and IMG_H defaults SHALL live in a shared package (conv_pkg), together with the conv stage's constants.
REQ-030 The row memory SHALL be one sub-module, line_mem (synchronous write, asynchronous or same-cycle read of the old value, depth IMG_W), instantiated twice.
REQ-031 o_dato0/1/2 SHALL connect directly to the conv stage's i_dato0/1/2.

Verification (IMG_W=4, IMG_H=4)
REQ-032 Stream pixels 1..16 with i_sof on 1 -> o_valid first high 1 clk after pixel 9 with (dato2,dato1,dato0)=(1,5,9); last output is (8,12,16) with o_eol=o_eof=1.
REQ-033 Same stream with i_valid low every other cycle -> identical output sequence; o_valid pulses only after accepted pixels; outputs hold during gaps.
REQ-034 After 6 pixels, assert i_sof on the 7th pixel (value 100), then stream 100..115 -> no o_valid until the 9th pixel of the new frame, first column (100,104,108).
REQ-035 Assert i_reset asynchronously after pixel 10 -> all outputs 0 without a clock edge; restart with 1..16 reproduces REQ-032 exactly.
REQ-036 Two back-to-back frames 1..16 then 17..32 without a second i_sof -> frame 2 first valid is (17,21,25); no column mixes frame 1 and frame 2 data.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared constants and types for the 3x3 convolution front end.
//   - Default pixel width and padded feature-map geometry (417 x 417).
//   - Kernel geometry of the conv stage fed by line_buf_3row.
//   - fill_t: how many complete rows the line buffer currently holds.
//     The buffer only produces valid 3-pixel columns once two earlier rows
//     of the same frame are stored, so the count saturates at FILL_FULL.
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DEF_BIT_LEN = 8;
    localparam int DEF_IMG_W   = 417;
    localparam int DEF_IMG_H   = 417;

    localparam int KERNEL_SIZE = 3;
    localparam int KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_t;

    // Saturating step of the row-fill count at the end of a row.
    function automatic fill_t fill_inc(input fill_t f);
        case (f)
            FILL_EMPTY: return FILL_ONE;
            default:    return FILL_FULL;
        endcase
    endfunction

endpackage

// File: rtl/line_mem.sv
// ---------------------------------------------------------------------------
// line_mem
// One row of pixel storage, DEPTH entries of WIDTH bits.
// Reads are combinational, so in the cycle that writes an address the read
// port still shows the value stored before that edge.
// Contents are never reset; the owner guarantees stale data is not consumed.
//
// Ports:
//   clk      - write clock
//   we       - write enable
//   addr     - shared read/write address (column)
//   wr_data  - data written at addr on the rising edge when we=1
//   rd_data  - current contents of addr
// ---------------------------------------------------------------------------
module line_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 417,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/line_buf_3row.sv
// ---------------------------------------------------------------------------
// line_buf_3row
// Turns a raster pixel stream into vertical 3-pixel columns for a 3x3 conv
// stage. Two line memories delay the stream by one and two rows; each
// accepted pixel emits, one clock later, (row r-2, row r-1, row r) at the
// same column. o_valid only rises once two full rows of the current frame
// are stored, so columns never mix frames or expose unwritten memory.
//
// Ports:
//   i_Clk     - clock, rising edge
//   i_reset   - asynchronous active-high reset
//   i_pix     - raster-order pixel
//   i_valid   - i_pix accepted this cycle
//   i_sof     - with i_valid, marks pixel (row 0, col 0)
//   o_dato0   - current row r       (LSB lane of conv stage)
//   o_dato1   - row r-1, same column
//   o_dato2   - row r-2, same column (MSB lane)
//   o_valid   - o_dato0..2 form a valid column
//   o_eol     - valid column is the last column of the row
//   o_eof     - valid column is the last column of the last row
// ---------------------------------------------------------------------------
module line_buf_3row
    import conv_pkg::*;
#(
    parameter int BIT_LEN = DEF_BIT_LEN,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H
) (
    input  logic               i_Clk,
    input  logic               i_reset,
    input  logic [BIT_LEN-1:0] i_pix,
    input  logic               i_valid,
    input  logic               i_sof,
    output logic [BIT_LEN-1:0] o_dato0,
    output logic [BIT_LEN-1:0] o_dato1,
    output logic [BIT_LEN-1:0] o_dato2,
    output logic               o_valid,
    output logic               o_eol,
    output logic               o_eof
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col, col_next, eff_col;
    logic [ROW_W-1:0] row, row_next, eff_row;
    fill_t            fill, fill_next, eff_fill;

    logic [BIT_LEN-1:0] line0_rd;
    logic [BIT_LEN-1:0] line1_rd;

    // line0 holds row r-1; on each accepted pixel its old entry shifts down
    // into line1 (row r-2) and the new pixel takes its place.
    line_mem #(
        .WIDTH  (BIT_LEN),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_line0 (
        .clk     (i_Clk),
        .we      (i_valid),
        .addr    (eff_col),
        .wr_data (i_pix),
        .rd_data (line0_rd)
    );

    line_mem #(
        .WIDTH  (BIT_LEN),
        .DEPTH  (IMG_W),
        .ADDR_W (COL_W)
    ) u_line1 (
        .clk     (i_Clk),
        .we      (i_valid),
        .addr    (eff_col),
        .wr_data (line0_rd),
        .rd_data (line1_rd)
    );

    // A start-of-frame pixel restarts the position at (0,0) with an empty
    // buffer no matter where the counters were, so an aborted frame simply
    // gets overwritten.
    always_comb begin
        eff_col   = i_sof ? '0 : col;
        eff_row   = i_sof ? '0 : row;
        eff_fill  = i_sof ? FILL_EMPTY : fill;
        col_next  = col;
        row_next  = row;
        fill_next = fill;
        if (i_valid) begin
            col_next  = eff_col + 1'b1;
            row_next  = eff_row;
            fill_next = eff_fill;
            if (eff_col == COL_LAST) begin
                col_next = '0;
                if (eff_row == ROW_LAST) begin
                    // Frame end empties the buffer so the next frame starts clean.
                    row_next  = '0;
                    fill_next = FILL_EMPTY;
                end else begin
                    row_next  = eff_row + 1'b1;
                    fill_next = fill_inc(eff_fill);
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            col  <= '0;
            row  <= '0;
            fill <= FILL_EMPTY;
        end else begin
            col  <= col_next;
            row  <= row_next;
            fill <= fill_next;
        end
    end

    // Data lanes hold through idle cycles; the strobes are single-cycle.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            o_dato0 <= '0;
            o_dato1 <= '0;
            o_dato2 <= '0;
            o_valid <= 1'b0;
            o_eol   <= 1'b0;
            o_eof   <= 1'b0;
        end else if (i_valid) begin
            o_dato0 <= i_pix;
            o_dato1 <= line0_rd;
            o_dato2 <= line1_rd;
            o_valid <= (eff_fill == FILL_FULL);
            o_eol   <= (eff_fill == FILL_FULL) && (eff_col == COL_LAST);
            o_eof   <= (eff_fill == FILL_FULL) && (eff_col == COL_LAST)
                       && (eff_row == ROW_LAST);
        end else begin
            o_valid <= 1'b0;
            o_eol   <= 1'b0;
            o_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buf_3row.sv
// ---------------------------------------------------------------------------
// tb_line_buf_3row
// Directed bench for line_buf_3row on a 4x4 image. Expected columns come
// from the raster position of each pixel within its frame: for frame index
// k (0..15) with value base+k, a valid column appears for k >= 8 and holds
// (base+k-8, base+k-4, base+k).
// ---------------------------------------------------------------------------
module tb_line_buf_3row;

    localparam int BW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clock;
    logic          reset;
    logic [BW-1:0] pix;
    logic          pixValid;
    logic          sof;
    logic [BW-1:0] dato0, dato1, dato2;
    logic          outValid, eol, eof;

    int assertCount;
    int failCount;

    line_buf_3row #(
        .BIT_LEN (BW),
        .IMG_W   (W),
        .IMG_H   (H)
    ) dut (
        .i_Clk   (clock),
        .i_reset (reset),
        .i_pix   (pix),
        .i_valid (pixValid),
        .i_sof   (sof),
        .o_dato0 (dato0),
        .o_dato1 (dato1),
        .o_dato2 (dato2),
        .o_valid (outValid),
        .o_eol   (eol),
        .o_eof   (eof)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one input cycle at the falling edge and let one rising edge pass;
    // outputs are then sampled 1 ns after that edge.
    task automatic applyStimulus(input logic [BW-1:0] p, input logic v,
                                 input logic s);
        @(negedge clock);
        pix      = p;
        pixValid = v;
        sof      = s;
        @(posedge clock);
        #1;
    endtask

    // Stream count pixels base, base+1, ... of one frame starting at frame
    // index 0. With gaps, an idle cycle follows every pixel and the outputs
    // must hold with strobes low.
    task automatic runPixels(input int base, input int count, input bit withSof,
                             input bit gaps);
        logic [31:0] expFull;
        logic [31:0] expCtl;
        bit          fullKnown;
        for (int k = 0; k < count; k++) begin
            applyStimulus(BW'(base + k), 1'b1, withSof && (k == 0));
            fullKnown = (k >= 2 * W);
            expCtl = {21'd0, fullKnown, fullKnown && (k % W == W - 1),
                      fullKnown && (k == W * H - 1), BW'(base + k)};
            expFull = {5'd0, expCtl[10:8], BW'(base + k - 2 * W),
                       BW'(base + k - W), BW'(base + k)};
            checkOutput($sformatf("px%0d ctl", base + k),
                        {21'd0, outValid, eol, eof, dato0}, expCtl);
            if (fullKnown)
                checkOutput($sformatf("px%0d column", base + k),
                            {5'd0, outValid, eol, eof, dato2, dato1, dato0}, expFull);
            if (gaps) begin
                applyStimulus(8'hEE, 1'b0, 1'b0);
                checkOutput($sformatf("gap%0d ctl", base + k),
                            {21'd0, outValid, eol, eof, dato0},
                            {21'd0, 3'b000, BW'(base + k)});
                if (fullKnown)
                    checkOutput($sformatf("gap%0d hold", base + k),
                                {5'd0, outValid, eol, eof, dato2, dato1, dato0},
                                {5'd0, 3'b000, expFull[23:0]});
            end
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        pix         = '0;
        pixValid    = 1'b0;
        sof         = 1'b0;
        reset       = 1'b1;

        #12;
        checkOutput("reset state", {5'd0, outValid, eol, eof, dato2, dato1, dato0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] full frame 1..16");
        runPixels(1, 16, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("idle after frame strobes", {29'd0, outValid, eol, eof}, 32'd0);

        $display("[TB] frame with idle gaps");
        runPixels(1, 16, 1'b1, 1'b1);

        $display("[TB] mid-row restart");
        runPixels(1, 6, 1'b1, 1'b0);
        runPixels(100, 16, 1'b1, 1'b0);

        $display("[TB] async reset mid-frame");
        runPixels(1, 10, 1'b1, 1'b0);
        pixValid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset clears outputs",
                    {5'd0, outValid, eol, eof, dato2, dato1, dato0}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        runPixels(1, 16, 1'b0, 1'b0);

        $display("[TB] back-to-back frames");
        runPixels(1, 16, 1'b1, 1'b0);
        runPixels(17, 16, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
